quad_encoder_tx: RTL and testbench

Quadrature encoder emitter: the transmit end of the rotary-encoder interface that the RGB mixer's encoder inputs decode.
- Accepts a command of direction plus step count through a valid/ready handshake.
- Emits the matching A/B quadrature waveform at a programmable edge spacing.
- Used as an on-chip stimulus source and loopback driver for encoder-decoding channels, one instance per channel.

---
 rtl/quad_encoder_tx.sv | 119 +++++++++++
 tb/tb_quad_encoder_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_tx.sv
// rtl/quad_encoder_tx.sv - quadrature A/B emitter driven by direction/step/period commands
// Phase is stored directly as (A,B); one channel toggles per emitted edge.
module quad_encoder_tx #(
  parameter int CNT_WIDTH = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_dir,
  input  logic [CNT_WIDTH-1:0] cmd_steps,
  input  logic [DIV_WIDTH-1:0] cmd_period,
  input  logic                 abort,
  output logic                 enc_a,
  output logic                 enc_b,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic                   dir_q, dir_d;
  logic [CNT_WIDTH-1:0]   steps_q, steps_d;
  logic [DIV_WIDTH-1:0]   period_q, period_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic                   enc_a_q, enc_a_d;
  logic                   enc_b_q, enc_b_d;
  logic                   done_q, done_d;
  logic                   accept;
  logic [DIV_WIDTH-1:0]   eff_period;

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign enc_a      = enc_a_q;
  assign enc_b      = enc_b_q;
  assign done       = done_q;
  assign accept     = cmd_valid && cmd_ready;
  assign eff_period = (cmd_period == '0) ? DIV_ONE : cmd_period;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    steps_d  = steps_q;
    period_d = period_q;
    div_d    = div_q;
    enc_a_d  = enc_a_q;
    enc_b_d  = enc_b_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dir_d    = cmd_dir;
          period_d = eff_period;
          div_d    = eff_period;
          steps_d  = cmd_steps;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          steps_d = '0;
          div_d   = '0;
        end else if (div_q == DIV_ONE) begin
          // Increment: A <= ~B, B <= A; decrement walks the same ring backwards.
          if (dir_q) begin
            enc_a_d = ~enc_b_q;
            enc_b_d = enc_a_q;
          end else begin
            enc_a_d = enc_b_q;
            enc_b_d = ~enc_a_q;
          end
          div_d   = period_q;
          steps_d = steps_q - CNT_ONE;
          if (steps_q == CNT_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
            div_d   = '0;
          end
        end else begin
          div_d = div_q - DIV_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      steps_q  <= '0;
      period_q <= '0;
      div_q    <= '0;
      enc_a_q  <= 1'b0;
      enc_b_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      steps_q  <= steps_d;
      period_q <= period_d;
      div_q    <= div_d;
      enc_a_q  <= enc_a_d;
      enc_b_q  <= enc_b_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_quad_encoder_tx.sv
// tb/tb_quad_encoder_tx.sv - self-checking bench for quad_encoder_tx
// Expected waveforms come from edge-count arithmetic over a four-entry phase ring.
module tb_quad_encoder_tx;
  localparam int CW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_dir, abort;
  logic [CW-1:0] cmd_steps;
  logic [DW-1:0] cmd_period;
  logic          enc_a, enc_b, busy, done;

  int n_chk  = 0;
  int n_fail = 0;
  int pos    = 0;
  logic [1:0] ph_tab [4];

  typedef struct {
    bit         dir;
    int         steps;
    int         period;
    int         abort_at;
    logic [1:0] exp_ab;
    bit         exp_done;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  quad_encoder_tx #(.CNT_WIDTH(CW), .DIV_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .enc_a(enc_a), .enc_b(enc_b), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] phase_after(input int p0, input bit dir, input int e);
    return ph_tab[(p0 + (dir ? e : 3 * e)) % 4];
  endfunction

  // Entered and left just after a rising edge. abort_at: -1 none, 0 with accept, n>0 before edge T0+n.
  task automatic run_cmd(input bit dir, input int steps, input int period, input int abort_at,
                         output bit saw_done, output logic [1:0] final_ab);
    int p, end_t, a_eff, obs, e;
    bit exp_busy, exp_done;
    p     = (period == 0) ? 1 : period;
    end_t = steps * p;
    a_eff = (abort_at >= 1 && abort_at <= end_t) ? abort_at : -1;
    obs   = (a_eff > 0 ? a_eff : end_t) + 2;
    saw_done = 1'b0;
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_steps  = CW'(steps);
    cmd_period = DW'(period);
    abort      = (abort_at == 0);
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'($urandom);
    cmd_steps  = CW'($urandom);
    cmd_period = DW'($urandom);
    e = 0;
    for (int t = 0; t <= obs; t++) begin
      abort = (a_eff > 0 && t + 1 == a_eff);
      @(negedge clk);
      if (a_eff > 0 && t >= a_eff) begin
        e = ((a_eff - 1) / p < steps) ? (a_eff - 1) / p : steps;
        exp_busy = 1'b0;
        exp_done = 1'b0;
      end else begin
        e = (t / p < steps) ? t / p : steps;
        exp_busy = (t < end_t);
        exp_done = (t == end_t);
      end
      chk("phase", {enc_a, enc_b}, phase_after(pos, dir, e));
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("cmd_ready", cmd_ready, !exp_busy);
      if (done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    abort = 1'b0;
    pos = (pos + (dir ? e : 3 * e)) % 4;
    final_ab = {enc_a, enc_b};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         sd;
    logic [1:0] fab;
    int         st, pd, ab;

    ph_tab  = '{2'b00, 2'b10, 2'b11, 2'b01};
    vecs[0] = '{1'b1,   4, 3, -1, 2'b00, 1'b1};
    vecs[1] = '{1'b1,   8, 4, 10, 2'b11, 1'b0};
    vecs[2] = '{1'b1,   0, 5, -1, 2'b11, 1'b1};
    vecs[3] = '{1'b1,   3, 0, -1, 2'b10, 1'b1};
    vecs[4] = '{1'b0,   2, 1, -1, 2'b01, 1'b1};
    vecs[5] = '{1'b1, 255, 1, -1, 2'b11, 1'b1};
    vecs[6] = '{1'b0,   2, 2,  0, 2'b00, 1'b1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0;
    cmd_steps = '0; cmd_period = '0; abort = 1'b0;
    #1;
    chk("reset_phase", {enc_a, enc_b}, 2'b00);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ready", cmd_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].dir, vecs[i].steps, vecs[i].period, vecs[i].abort_at, sd, fab);
      chk($sformatf("vec%0d_final_phase", i), fab, vecs[i].exp_ab);
      chk($sformatf("vec%0d_done_seen", i), sd, vecs[i].exp_done);
    end

    // abort while idle must be ignored
    abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_abort_busy", busy, 0);
      chk("idle_abort_phase", {enc_a, enc_b}, ph_tab[pos]);
      chk("idle_abort_done", done, 0);
    end
    @(posedge clk); #1 abort = 1'b0;

    // asynchronous reset in the middle of a command
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd6; cmd_period = 16'd2;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("pre_reset_phase", {enc_a, enc_b}, phase_after(pos, 1'b1, 2));
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_phase", {enc_a, enc_b}, 2'b00);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_done", done, 0);
    chk("mid_reset_ready", cmd_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    pos = 0;
    @(negedge clk);
    chk("post_reset_done", done, 0);
    @(posedge clk); #1;
    run_cmd(1'b1, 1, 1, -1, sd, fab);
    chk("fresh_cmd_phase", fab, 2'b10);
    chk("fresh_cmd_done", sd, 1);

    for (int i = 0; i < 30; i++) begin
      st = $urandom_range(12, 0);
      pd = $urandom_range(5, 0);
      ab = -1;
      if ($urandom_range(3, 0) == 0) begin
        if (st * ((pd == 0) ? 1 : pd) > 0)
          ab = $urandom_range(st * ((pd == 0) ? 1 : pd), 1);
      end else if ($urandom_range(7, 0) == 0) begin
        ab = 0;
      end
      run_cmd(1'($urandom), st, pd, ab, sd, fab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
